testport_write_capture: RTL



---
 rtl/testport_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 53 +++++
 rtl/testport_write_capture.sv | 129 ++++++++++++
 3 files changed

// File: rtl/testport_pkg.sv
// Shared defaults and types for test-port write capture.
package testport_pkg;

  localparam logic [29:0] DEF_TEST_PORT    = 30'hFF;
  localparam logic [31:0] DEF_BEGIN_SYMBOL = 32'h00000932;
  localparam logic [31:0] DEF_END_SYMBOL   = 32'h00000D5D;
  localparam int          DEF_IDX_W        = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } cap_state_t;

  // Layout of one FIFO entry for the default index width; the top packs {data, idx} in this order.
  typedef struct packed {
    logic [31:0]          data;
    logic [DEF_IDX_W-1:0] idx;
  } cap_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO, first-word fall-through from registered storage; pop_dat valid when !empty.
// Push is refused only when full without a same-cycle pop; push+pop on a full FIFO keeps the count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign pop_dat = mem[rd_ptr];

  // Storage is reset too so a mid-run reset leaves no stale head data visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/testport_write_capture.sv
// Captures test-port stores between begin/end symbols into a FIFO; value visible the cycle after the write.
// Consumer stalls via out_ready; a capture into a full FIFO is dropped and flags overflow.
// Optional stall/drop statistics counters under TESTPORT_CAPTURE_STATS_EN.
module testport_write_capture
  import testport_pkg::*;
#(
  parameter logic [29:0] TEST_PORT    = DEF_TEST_PORT,
  parameter logic [31:0] BEGIN_SYMBOL = DEF_BEGIN_SYMBOL,
  parameter logic [31:0] END_SYMBOL   = DEF_END_SYMBOL,
  parameter int          DEPTH        = 8,
  parameter int          IDX_W        = DEF_IDX_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [29:0]              addr,
  input  logic [31:0]              data,
  input  logic                     ren,
  input  logic                     wen,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [31:0]              out_data,
  output logic [IDX_W-1:0]         out_index,
  output logic                     armed,
  output logic                     done,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [15:0]              dup_cnt,
  output logic [15:0]              drop_cnt
);

  localparam int EW = 32 + IDX_W;

  cap_state_t       state;
  logic             wen_q;
  logic [IDX_W-1:0] idx;
  logic             wr_evt;
  logic             port_evt;
  logic             capture;
  logic             pop;
  logic             drop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [EW-1:0]    head;
  logic             unused_ren;

  // A write held across stall cycles counts once, on its rising edge of wen.
  assign wr_evt   = wen & ~wen_q;
  assign port_evt = wr_evt & (addr == TEST_PORT);
  assign capture  = port_evt & (state == ARMED);
  assign out_valid = ~fifo_empty;
  assign pop      = out_valid & out_ready;
  assign drop     = capture & fifo_full & ~pop;
  assign out_data  = head[EW-1:IDX_W];
  assign out_index = head[IDX_W-1:0];
  assign unused_ren = ren;

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (capture),
    .push_dat ({data, idx}),
    .pop      (pop),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      wen_q    <= 1'b0;
      idx      <= '0;
      armed    <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wen_q <= wen;
      if (drop) overflow <= 1'b1;
      case (state)
        IDLE: begin
          if (port_evt && data == BEGIN_SYMBOL) begin
            state <= ARMED;
            armed <= 1'b1;
            idx   <= '0;
          end
        end
        ARMED: begin
          // Index advances even on a drop so the consumer can see the gap.
          if (port_evt) begin
            idx <= idx + 1'b1;
            if (data == END_SYMBOL) begin
              state <= DONE;
              armed <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE:    ;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TESTPORT_CAPTURE_STATS_EN
  logic [15:0] dup_q;
  logic [15:0] drop_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dup_q  <= '0;
      drop_q <= '0;
    end else begin
      if (wen && wen_q && dup_q != 16'hFFFF) dup_q <= dup_q + 1'b1;
      if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 1'b1;
    end
  end

  assign dup_cnt  = dup_q;
  assign drop_cnt = drop_q;
`else
  assign dup_cnt  = '0;
  assign drop_cnt = '0;
`endif

endmodule
